// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit
//   Decodes the ID-stage opcode into a 9-bit control word and carries it
//   through the ID/EX, EX/MEM and MEM/WB registers. It also detects hazards,
//   applies external stalls and branch/jump flushes, and can drive operand
//   forwarding selects.
//   Optional feature macro: FORWARD_EN. When it is defined, EX/MEM and MEM/WB
//   forwarding is enabled and only load-use hazards stall. When it is
//   undefined, fwd_a/fwd_b stay at 00 and any RAW dependence on an ID/EX or
//   EX/MEM producer stalls the ID instruction.
//   Control word: {ResultSrc,MemRead,MemWrite,ALUSrc,ImmSrc[1:0],RegWrite,Branch,Jump}
module pipelined_control_unit #(
    parameter int OPCODE_W = 4,
    parameter int REG_AW   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid,
    input  logic [OPCODE_W-1:0] id_opcode,
    input  logic [REG_AW-1:0]   id_rs1,
    input  logic [REG_AW-1:0]   id_rs2,
    input  logic [REG_AW-1:0]   id_rd,
    input  logic                stall_ext,
    input  logic                flush,
    output logic                hazard_stall,
    output logic [8:0]          ex_ctrl,
    output logic [REG_AW-1:0]   ex_rd,
    output logic [8:0]          mem_ctrl,
    output logic [REG_AW-1:0]   mem_rd,
    output logic [8:0]          wb_ctrl,
    output logic [REG_AW-1:0]   wb_rd,
    output logic [1:0]          fwd_a,
    output logic [1:0]          fwd_b
);

    localparam logic [8:0] CTRL_NOP = 9'b0000_11_000;
    localparam int BIT_MEMREAD  = 7;
    localparam int BIT_REGWRITE = 2;

    // An opcode with any bit set above bit 3 is not part of the ISA and
    // decodes as NOP. An invalid ID slot also decodes as NOP.
    function automatic logic [8:0] decode(input logic valid,
                                          input logic [OPCODE_W-1:0] op);
        logic [8:0] c;
        c = CTRL_NOP;
        if (valid && ((op >> 4) == '0)) begin
            case (op[3:0])
                4'h0, 4'h1, 4'h2,
                4'h3, 4'h4, 4'h5: c = 9'b0000_11_100;
                4'h6:             c = 9'b0001_10_100;
                4'h7:             c = 9'b1101_01_100;
                4'h8:             c = 9'b0011_01_000;
                4'h9:             c = 9'b0001_01_100;
                4'hA:             c = 9'b0001_00_100;
                4'hB, 4'hC:       c = 9'b0000_01_010;
                4'hD:             c = 9'b0000_00_001;
                default:          c = CTRL_NOP;
            endcase
        end
        return c;
    endfunction

    logic [8:0] id_ctrl;
    logic       ex_prod;
    logic       mem_prod;
    logic       load_use;
    logic       raw_dep;
    logic       flush_live;
    logic       bubble;

`ifdef FORWARD_EN
    logic [REG_AW-1:0] ex_rs1;
    logic [REG_AW-1:0] ex_rs2;
    logic              wb_prod;
`endif

    // Only a RegWrite field with a nonzero rd counts as a producer.
    always_comb begin
        id_ctrl  = decode(id_valid, id_opcode);
        ex_prod  = ex_ctrl[BIT_REGWRITE] && (ex_rd != '0);
        mem_prod = mem_ctrl[BIT_REGWRITE] && (mem_rd != '0);
        load_use = ex_ctrl[BIT_MEMREAD] && (ex_rd != '0) &&
                   ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    end

`ifdef FORWARD_EN
    // Forwarding covers every RAW except a load-use, so nothing else stalls.
    // EX/MEM is the younger producer and wins ties.
    always_comb begin
        raw_dep = 1'b0;
        wb_prod = wb_ctrl[BIT_REGWRITE] && (wb_rd != '0);
        fwd_a   = 2'b00;
        fwd_b   = 2'b00;
        if (mem_prod && (mem_rd == ex_rs1))     fwd_a = 2'b10;
        else if (wb_prod && (wb_rd == ex_rs1))  fwd_a = 2'b01;
        if (mem_prod && (mem_rd == ex_rs2))     fwd_b = 2'b10;
        else if (wb_prod && (wb_rd == ex_rs2))  fwd_b = 2'b01;
    end
`else
    // Without forwarding, the ID instruction waits until its producers reach WB.
    always_comb begin
        fwd_a   = 2'b00;
        fwd_b   = 2'b00;
        raw_dep = ((id_rs1 != '0) &&
                   ((ex_prod && (ex_rd == id_rs1)) || (mem_prod && (mem_rd == id_rs1)))) ||
                  ((id_rs2 != '0) &&
                   ((ex_prod && (ex_rd == id_rs2)) || (mem_prod && (mem_rd == id_rs2))));
    end
`endif

    // A flush that arrives during an external stall is ignored, because the
    // source keeps holding it. A live flush kills the ID instruction, so that
    // instruction can never cause a stall.
    always_comb begin
        flush_live   = flush && !stall_ext;
        hazard_stall = id_valid && !flush_live && (load_use || raw_dep);
        bubble       = flush_live || hazard_stall;
    end

    // Pipeline registers: hold everything on stall_ext, otherwise advance and
    // insert a NOP into ID/EX on a flush or a hazard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_ctrl  <= CTRL_NOP;
            ex_rd    <= '0;
            mem_ctrl <= CTRL_NOP;
            mem_rd   <= '0;
            wb_ctrl  <= CTRL_NOP;
            wb_rd    <= '0;
`ifdef FORWARD_EN
            ex_rs1   <= '0;
            ex_rs2   <= '0;
`endif
        end else if (!stall_ext) begin
            mem_ctrl <= ex_ctrl;
            mem_rd   <= ex_rd;
            wb_ctrl  <= mem_ctrl;
            wb_rd    <= mem_rd;
            if (bubble || !id_valid) begin
                ex_ctrl <= CTRL_NOP;
                ex_rd   <= '0;
`ifdef FORWARD_EN
                ex_rs1  <= '0;
                ex_rs2  <= '0;
`endif
            end else begin
                ex_ctrl <= id_ctrl;
                ex_rd   <= id_rd;
`ifdef FORWARD_EN
                ex_rs1  <= id_rs1;
                ex_rs2  <= id_rs2;
`endif
            end
        end
    end

    wire unused_ok = ex_prod;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// tb_pipelined_control_unit
//   Directed bench for pipelined_control_unit with hand-computed control words.
//   The expectations follow the FORWARD_EN build setting.
module tb_pipelined_control_unit;

    localparam logic [8:0] NOP = 9'h018;
    localparam logic [8:0] ALU = 9'h01C;  // opcodes 0-5
    localparam logic [8:0] LDW = 9'h1AC;  // opcode 7

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [3:0] id_opcode;
    logic [3:0] id_rs1;
    logic [3:0] id_rs2;
    logic [3:0] id_rd;
    logic       stall_ext;
    logic       flush;
    logic       hazard_stall;
    logic [8:0] ex_ctrl;
    logic [8:0] mem_ctrl;
    logic [8:0] wb_ctrl;
    logic [3:0] ex_rd;
    logic [3:0] mem_rd;
    logic [3:0] wb_rd;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    int n_checks = 0;
    int n_errors = 0;
    logic [8:0] dec_tab [16];

    pipelined_control_unit #(.OPCODE_W(4), .REG_AW(4)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .stall_ext(stall_ext), .flush(flush), .hazard_stall(hazard_stall),
        .ex_ctrl(ex_ctrl), .ex_rd(ex_rd), .mem_ctrl(mem_ctrl), .mem_rd(mem_rd),
        .wb_ctrl(wb_ctrl), .wb_rd(wb_rd), .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [3:0] op, input logic [3:0] r1,
                          input logic [3:0] r2, input logic [3:0] rd);
        id_valid  = v;
        id_opcode = op;
        id_rs1    = r1;
        id_rs2    = r2;
        id_rd     = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        set_id(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
        repeat (3) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        dec_tab[0]  = 9'h01C; dec_tab[1]  = 9'h01C; dec_tab[2]  = 9'h01C; dec_tab[3]  = 9'h01C;
        dec_tab[4]  = 9'h01C; dec_tab[5]  = 9'h01C; dec_tab[6]  = 9'h034; dec_tab[7]  = 9'h1AC;
        dec_tab[8]  = 9'h068; dec_tab[9]  = 9'h02C; dec_tab[10] = 9'h024; dec_tab[11] = 9'h00A;
        dec_tab[12] = 9'h00A; dec_tab[13] = 9'h001; dec_tab[14] = 9'h018; dec_tab[15] = 9'h018;

        rst_n = 1'b0;
        stall_ext = 1'b0;
        flush = 1'b0;
        set_id(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
        #12;
        check("rst_ex_ctrl", ex_ctrl, NOP);
        check("rst_mem_ctrl", mem_ctrl, NOP);
        check("rst_wb_ctrl", wb_ctrl, NOP);
        check("rst_rds", {ex_rd, mem_rd, wb_rd}, 0);
        check("rst_hazard", hazard_stall, 0);
        check("rst_fwd", {fwd_a, fwd_b}, 0);
        #1 rst_n = 1'b1;

        // Opcodes 0..F back-to-back
        for (int i = 0; i < 16; i++) begin
            set_id(1'b1, 4'(i), 4'h0, 4'h0, 4'(i));
            tick();
            check($sformatf("dec_ex_ctrl_op%0d", i), ex_ctrl, dec_tab[i]);
            check($sformatf("dec_ex_rd_op%0d", i), ex_rd, i);
            if (i >= 2) check($sformatf("dec_wb_ctrl_op%0d", i - 2), wb_ctrl, dec_tab[i - 2]);
        end
        drain();
        check("invalid_nop_ex", ex_ctrl, NOP);
        check("drain_wb", wb_ctrl, NOP);

        // A load to x0 is never a producer
        set_id(1'b1, 4'h7, 4'h0, 4'h0, 4'h0);
        tick();
        set_id(1'b1, 4'h0, 4'h0, 4'h0, 4'h1);
        #1 check("x0_no_hazard", hazard_stall, 0);
        drain();

        // Load-use: a load to x3, then an instruction that reads x3
        set_id(1'b1, 4'h7, 4'h0, 4'h0, 4'h3);
        #1 check("lu_no_hazard_before", hazard_stall, 0);
        tick();
        check("lu_load_in_ex", ex_ctrl, LDW);
        set_id(1'b1, 4'h0, 4'h3, 4'h0, 4'h4);
        #1 check("lu_hazard", hazard_stall, 1);
        tick();
        check("lu_bubble", ex_ctrl, NOP);
        check("lu_load_in_mem", mem_ctrl, LDW);
`ifdef FORWARD_EN
        check("lu_hazard_released", hazard_stall, 0);
        tick();
        check("lu_consumer_ex", ex_ctrl, ALU);
        check("lu_fwd_a", fwd_a, 2'b01);
`else
        check("lu_hazard_mem", hazard_stall, 1);
        tick();
        check("lu_bubble2", ex_ctrl, NOP);
        check("lu_load_in_wb", wb_ctrl, LDW);
        check("lu_hazard_released", hazard_stall, 0);
        tick();
        check("lu_consumer_ex", ex_ctrl, ALU);
        check("lu_consumer_rd", ex_rd, 4);
`endif
        drain();

        // ALU RAW: writes x5, then an instruction that reads x5 as rs2
        set_id(1'b1, 4'h0, 4'h0, 4'h0, 4'h5);
        tick();
        set_id(1'b1, 4'h1, 4'h0, 4'h5, 4'h6);
`ifdef FORWARD_EN
        #1 check("raw_no_stall", hazard_stall, 0);
        tick();
        check("raw_consumer_ex", ex_rd, 6);
        check("raw_fwd_b", fwd_b, 2'b10);
`else
        #1 check("raw_stall1", hazard_stall, 1);
        tick();
        check("raw_bubble1", ex_ctrl, NOP);
        check("raw_stall2", hazard_stall, 1);
        tick();
        check("raw_bubble2", ex_ctrl, NOP);
        check("raw_stall_done", hazard_stall, 0);
        tick();
        check("raw_consumer_ex", ex_ctrl, ALU);
        check("raw_consumer_rd", ex_rd, 6);
        check("raw_fwd_b_zero", fwd_b, 2'b00);
`endif
        drain();

        // A flush while a load is in EX and a dependent instruction is in ID
        set_id(1'b1, 4'h7, 4'h0, 4'h0, 4'h3);
        tick();
        set_id(1'b1, 4'h0, 4'h3, 4'h0, 4'h4);
        flush = 1'b1;
        #1 check("flush_hazard_zero", hazard_stall, 0);
        tick();
        flush = 1'b0;
        check("flush_ex_nop", ex_ctrl, NOP);
        check("flush_ex_rd", ex_rd, 0);
        check("flush_mem_load", mem_ctrl, LDW);
        drain();

        // External stall for three cycles; a flush in the middle is ignored
        set_id(1'b1, 4'hA, 4'h0, 4'h0, 4'h1); tick();
        set_id(1'b1, 4'h8, 4'h0, 4'h0, 4'h2); tick();
        set_id(1'b1, 4'h9, 4'h0, 4'h0, 4'h7); tick();
        set_id(1'b1, 4'h6, 4'h0, 4'h0, 4'h8);
        stall_ext = 1'b1;
        for (int c = 0; c < 3; c++) begin
            flush = (c == 1);
            tick();
            check($sformatf("stall_ex_ctrl_c%0d", c), ex_ctrl, 9'h02C);
            check($sformatf("stall_mem_ctrl_c%0d", c), mem_ctrl, 9'h068);
            check($sformatf("stall_wb_ctrl_c%0d", c), wb_ctrl, 9'h024);
            check($sformatf("stall_rds_c%0d", c), {ex_rd, mem_rd, wb_rd}, 12'h721);
        end
        stall_ext = 1'b0;
        flush = 1'b0;
        tick();
        check("resume_ex", {ex_ctrl, ex_rd}, {9'h034, 4'h8});
        check("resume_mem", {mem_ctrl, mem_rd}, {9'h02C, 4'h7});
        check("resume_wb", {wb_ctrl, wb_rd}, {9'h068, 4'h2});

        // Asynchronous reset with RegWrite in every stage
        set_id(1'b1, 4'h0, 4'h0, 4'h0, 4'h9); tick();
        set_id(1'b1, 4'h1, 4'h0, 4'h0, 4'hA); tick();
        set_id(1'b1, 4'h2, 4'h0, 4'h0, 4'hB); tick();
        set_id(1'b1, 4'h3, 4'hB, 4'h0, 4'hC);
        check("pre_rst_wb", {wb_ctrl, wb_rd}, {ALU, 4'h9});
`ifndef FORWARD_EN
        #1 check("pre_rst_hazard", hazard_stall, 1);
`endif
        #2 rst_n = 1'b0;
        #1;
        check("arst_ex_ctrl", ex_ctrl, NOP);
        check("arst_mem_ctrl", mem_ctrl, NOP);
        check("arst_wb_ctrl", wb_ctrl, NOP);
        check("arst_rds", {ex_rd, mem_rd, wb_rd}, 0);
        check("arst_hazard", hazard_stall, 0);
        check("arst_fwd", {fwd_a, fwd_b}, 0);
        #1 rst_n = 1'b1;
        set_id(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
